// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported data memory between instruction fetch and the memory stage.
// Data has priority; a saturating starvation counter lets a waiting fetch through periodically.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_m
);

    typedef enum logic {StIdle, StBusy} state_t;

    localparam logic [3:0] LatInit   = 4'(MEM_LATENCY);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  starve_q;
    logic        owner_d_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic        read_q;
    logic        write_q;

    logic idle;
    logic busy;
    logic fetch_win;
    logic data_win;
    logic last_cycle;
    logic if_out;
    logic d_out;

    assign idle       = (state_q == StIdle);
    assign busy       = (state_q == StBusy);
    assign fetch_win  = if_req & (~d_req | (starve_q == StarveMax));
    assign data_win   = d_req & ~fetch_win;
    assign last_cycle = busy & (cnt_q == 4'd1);

    // Grants are combinational, so they are also gated by reset to keep every output at zero.
    assign if_gnt = ~rst & idle & fetch_win;
    assign d_gnt  = ~rst & idle & data_win;

    assign if_rvalid = last_cycle & ~owner_d_q;
    assign d_rvalid  = last_cycle & owner_d_q;
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign d_rdata   = (d_rvalid & ~we_q) ? mem_rdata : 32'd0;

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_funct3 = funct3_q;
    assign mem_read   = read_q;
    assign mem_write  = write_q;

    // A transaction counts as outstanding from its grant cycle until its rvalid cycle.
    assign if_out   = if_gnt | (busy & ~owner_d_q);
    assign d_out    = d_gnt | (busy & owner_d_q);
    assign stall_if = ~rst & ((if_req & ~if_gnt) | (if_out & ~if_rvalid));
    assign stall_m  = ~rst & ((d_req & ~d_gnt) | (d_out & ~d_rvalid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            starve_q  <= 4'd0;
            owner_d_q <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            funct3_q  <= 3'd0;
            we_q      <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!if_req || fetch_win) begin
                        starve_q <= 4'd0;
                    end else if (data_win && starve_q < StarveMax) begin
                        starve_q <= starve_q + 4'd1;
                    end
                    if (fetch_win || data_win) begin
                        owner_d_q <= data_win;
                        addr_q    <= data_win ? d_addr : if_addr;
                        wdata_q   <= data_win ? d_wdata : 32'd0;
                        funct3_q  <= data_win ? d_funct3 : 3'd2;
                        we_q      <= data_win & d_we;
                        read_q    <= ~(data_win & d_we);
                        write_q   <= data_win & d_we;
                        cnt_q     <= LatInit;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected events with their cycle numbers,
// monitors pop and compare whenever a DUT strobes a grant, memory strobe or rvalid.
module tb_mem_port_arbiter;

    localparam int EvIfGnt = 0;
    localparam int EvDGnt  = 1;
    localparam int EvRd    = 2;
    localparam int EvWr    = 3;
    localparam int EvIfRv  = 4;
    localparam int EvDRv   = 5;

    typedef struct {
        int          inst;
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
    } ev_t;

    ev_t exp_q[$];
    int  nvec = 0;
    int  nfail = 0;
    int  cyc = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default latency, both requesters
    logic        rst, if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  d_funct3, mem_funct3;
    logic        mem_read, mem_write, stall_if, stall_m;

    // Instance B: MEM_LATENCY = 1, fetch only
    logic        b_rst, b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [2:0]  b_d_funct3, b_mem_funct3;
    logic        b_mem_read, b_mem_write, b_stall_if, b_stall_m;

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return (addr == 32'h10) ? 32'h0050_0093 : {addr[15:0], 16'hC0DE};
    endfunction

    assign mem_rdata   = mem_fn(mem_addr);
    assign b_mem_rdata = mem_fn(b_mem_addr);

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(3)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_m(stall_m)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(3)) u_dut_lat1 (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_funct3(b_d_funct3),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_funct3(b_mem_funct3),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(b_mem_rdata),
        .stall_if(b_stall_if), .stall_m(b_stall_m)
    );

    task automatic push(input int inst, input int kind, input int c, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] f);
        ev_t e;
        e.inst = inst; e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.f = f;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int inst, input int kind, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] f);
        ev_t e;
        nvec++;
        if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL event: got inst%0d kind%0d cyc%0d a=%h, required no event",
                     inst, kind, cyc, a);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst || e.kind != kind || e.cyc != cyc || e.a !== a || e.b !== b ||
                e.f !== f) begin
                nfail++;
                $display("FAIL event: got inst%0d kind%0d cyc%0d a=%h b=%h f=%0d, required inst%0d kind%0d cyc%0d a=%h b=%h f=%0d",
                         inst, kind, cyc, a, b, f, e.inst, e.kind, e.cyc, e.a, e.b, e.f);
            end
        end
    endtask

    task automatic mon(input int inst, input logic ig, input logic dg, input logic rd,
                       input logic wr, input logic irv, input logic drv, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] ird,
                       input logic [31:0] drd);
        if (ig)  check_ev(inst, EvIfGnt, 32'd0, 32'd0, 3'd0);
        if (dg)  check_ev(inst, EvDGnt, 32'd0, 32'd0, 3'd0);
        if (rd)  check_ev(inst, EvRd, addr, 32'd0, f3);
        if (wr)  check_ev(inst, EvWr, addr, wdata, f3);
        if (irv) check_ev(inst, EvIfRv, ird, 32'd0, 3'd0);
        if (drv) check_ev(inst, EvDRv, drd, 32'd0, 3'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) mon(0, if_gnt, d_gnt, mem_read, mem_write, if_rvalid, d_rvalid, mem_addr,
                      mem_wdata, mem_funct3, if_rdata, d_rdata);
        if (!b_rst) mon(1, b_if_gnt, b_d_gnt, b_mem_read, b_mem_write, b_if_rvalid, b_d_rvalid,
                        b_mem_addr, b_mem_wdata, b_mem_funct3, b_if_rdata, b_d_rdata);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s at cyc%0d: got %h, required %h", name, cyc, got, want);
        end
    endtask

    task automatic chk_all_zero(input string name);
        logic [138:0] v;
        v = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_wdata,
             mem_funct3, mem_read, mem_write, stall_if, stall_m};
        nvec++;
        if (v != '0) begin
            nfail++;
            $display("FAIL %s at cyc%0d: outputs %h, required all zero", name, cyc, v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_if(input logic [31:0] addr, input int n);
        int got = 0;
        int guard = 0;
        if_addr = addr;
        if_req  = 1'b1;
        while (got < n && guard < 100) begin
            @(negedge clk);
            guard++;
            if (if_gnt) got++;
        end
        if (got < n) begin
            nvec++; nfail++;
            $display("FAIL if_gnt_wait: got %0d grants, required %0d", got, n);
        end
        step();
        if_req = 1'b0;
    endtask

    task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int n);
        int got = 0;
        int guard = 0;
        d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3;
        d_req = 1'b1;
        while (got < n && guard < 100) begin
            @(negedge clk);
            guard++;
            if (d_gnt) got++;
        end
        if (got < n) begin
            nvec++; nfail++;
            $display("FAIL d_gnt_wait: got %0d grants, required %0d", got, n);
        end
        step();
        d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int got;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_funct3 = '0;
        b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_d_addr = '0; b_d_wdata = '0; b_d_funct3 = '0;
        repeat (3) step();
        chk_all_zero("reset_outputs");
        rst = 1'b0; b_rst = 1'b0;
        repeat (2) step();

        // Lone fetch
        t = cyc;
        push(0, EvIfGnt, t, 32'd0, 32'd0, 3'd0);
        push(0, EvRd, t + 1, 32'h10, 32'd0, 3'd2);
        push(0, EvIfRv, t + 2, 32'h0050_0093, 32'd0, 3'd0);
        fork
            issue_if(32'h10, 1);
            begin
                @(negedge clk); chk("stall_if_T", {31'd0, stall_if}, 32'd1);
                @(negedge clk); chk("stall_if_T1", {31'd0, stall_if}, 32'd1);
                @(negedge clk); chk("stall_if_T2", {31'd0, stall_if}, 32'd0);
            end
        join
        repeat (3) step();

        // Simultaneous requests: data first, fetch after the data transaction
        t = cyc;
        push(0, EvDGnt, t, 32'd0, 32'd0, 3'd0);
        push(0, EvRd, t + 1, 32'h200, 32'd0, 3'd4);
        push(0, EvDRv, t + 2, 32'h0200_C0DE, 32'd0, 3'd0);
        push(0, EvIfGnt, t + 3, 32'd0, 32'd0, 3'd0);
        push(0, EvRd, t + 4, 32'h14, 32'd0, 3'd2);
        push(0, EvIfRv, t + 5, 32'h0014_C0DE, 32'd0, 3'd0);
        fork
            issue_d(1'b0, 32'h200, 32'd0, 3'd4, 1);
            issue_if(32'h14, 1);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("stall_if_wait", {31'd0, stall_if}, 32'd1);
                chk("stall_m_busy", {31'd0, stall_m}, 32'd1);
                @(negedge clk);
                chk("stall_m_done", {31'd0, stall_m}, 32'd0);
            end
        join
        repeat (4) step();

        // Starvation: three data grants, then fetch, then data again
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            push(0, EvDGnt, t + 3 * k, 32'd0, 32'd0, 3'd0);
            push(0, EvRd, t + 3 * k + 1, 32'h300, 32'd0, 3'd2);
            push(0, EvDRv, t + 3 * k + 2, 32'h0300_C0DE, 32'd0, 3'd0);
        end
        push(0, EvIfGnt, t + 9, 32'd0, 32'd0, 3'd0);
        push(0, EvRd, t + 10, 32'h20, 32'd0, 3'd2);
        push(0, EvIfRv, t + 11, 32'h0020_C0DE, 32'd0, 3'd0);
        push(0, EvDGnt, t + 12, 32'd0, 32'd0, 3'd0);
        push(0, EvRd, t + 13, 32'h300, 32'd0, 3'd2);
        push(0, EvDRv, t + 14, 32'h0300_C0DE, 32'd0, 3'd0);
        fork
            issue_d(1'b0, 32'h300, 32'd0, 3'd2, 4);
            issue_if(32'h20, 1);
        join
        repeat (4) step();

        // Store: write strobe only, d_rdata zero
        t = cyc;
        push(0, EvDGnt, t, 32'd0, 32'd0, 3'd0);
        push(0, EvWr, t + 1, 32'h40, 32'hDEAD_BEEF, 3'd2);
        push(0, EvDRv, t + 2, 32'd0, 32'd0, 3'd0);
        issue_d(1'b1, 32'h40, 32'hDEAD_BEEF, 3'd2, 1);
        repeat (3) step();

        // Reset in T+1 of a fetch: outputs cleared, no rvalid, fresh grant after release
        t = cyc;
        push(0, EvIfGnt, t, 32'd0, 32'd0, 3'd0);
        if_addr = 32'h10;
        if_req  = 1'b1;
        step();
        rst = 1'b1;
        if_addr = 32'h24;
        @(negedge clk);
        chk_all_zero("reset_mid_txn");
        repeat (2) step();
        rst = 1'b0;
        t = cyc;
        push(0, EvIfGnt, t, 32'd0, 32'd0, 3'd0);
        push(0, EvRd, t + 1, 32'h24, 32'd0, 3'd2);
        push(0, EvIfRv, t + 2, 32'h0024_C0DE, 32'd0, 3'd0);
        issue_if(32'h24, 1);
        repeat (4) step();

        // MEM_LATENCY = 1: back-to-back fetches every two cycles
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            push(1, EvIfGnt, t + 2 * k, 32'd0, 32'd0, 3'd0);
            push(1, EvRd, t + 2 * k + 1, 32'h30, 32'd0, 3'd2);
            push(1, EvIfRv, t + 2 * k + 1, 32'h0030_C0DE, 32'd0, 3'd0);
        end
        b_if_addr = 32'h30;
        b_if_req  = 1'b1;
        got = 0;
        for (int g = 0; g < 50 && got < 3; g++) begin
            @(negedge clk);
            if (b_if_gnt) got++;
        end
        if (got < 3) begin
            nvec++; nfail++;
            $display("FAIL lat1_gnt_wait: got %0d grants, required 3", got);
        end
        step();
        b_if_req = 1'b0;
        repeat (4) step();

        nvec++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
